mdio_slave: RTL and testbench
=============================

MDIO_SLAVE -- requirements
Module: mdio_slave

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'b00001: the PHY address this responder answers.
REQ-002 SHALL have parameter PREAMBLE_MIN, default 32: the minimum count of consecutive 1 bits accepted as a preamble.
REQ-003 SHALL have parameter PHY_ID1 = 16'h0022 and PHY_ID2 = 16'h1622: the values returned for registers 2 and 3.
REQ-004 clk  in  1  system clock; frequency SHALL be at least 8x the MDC frequency.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mdc  in  1  management clock from the station manager; asynchronous to clk.
REQ-007 mdio_i  in  1  MDIO pad input; asynchronous to clk.
REQ-008 mdio_o  out  1  MDIO output data.
REQ-009 mdio_oe  out  1  MDIO output enable; 1 drives the pad.
REQ-010 link_in  in  1  link status to report.
REQ-011 speed_in  in  2  speed to report: 00 = 10M, 01 = 100M, 10 = 1000M.
REQ-012 ctrl_reg  out  16  current value of register 0.
REQ-013 wr_strobe  out  1  one-clk pulse for each accepted write frame addressed to this PHY.
REQ-014 wr_addr  out  5 and wr_data  out  16  register address and data of the last accepted write; held until the next accepted write.
REQ-015 frame_err  out  1  one-clk pulse on a malformed frame.

Function
REQ-016 mdc and mdio_i SHALL each pass through a 2-FF synchronizer.
REQ-017 The synchronized MDC SHALL be edge-detected:
- mdc_rise = sync & ~prev.
- mdc_fall = ~sync & prev.
REQ-018 MDIO SHALL be sampled only on mdc_rise; all outputs SHALL change only on mdc_fall, except the pulses and the ctrl_reg update.
REQ-019 The FSM SHALL have the states IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP, and each state SHALL advance per sampled bit using a bit counter.
REQ-020 IDLE SHALL count consecutive sampled 1s, saturating at 63; a sampled 0 SHALL reset the count to 0.
REQ-021 A sampled 0 with count >= PREAMBLE_MIN SHALL be taken as ST bit 0 and move the FSM to ST.
REQ-022 In ST, a sampled 1 SHALL lead to OP; a sampled 0 SHALL pulse frame_err and return the FSM to IDLE with count 0.
REQ-023 OP SHALL take 2 bits: 10 = read, 01 = write, 00 or 11 = frame_err and return to IDLE.
REQ-024 PHYAD and REGAD SHALL each shift in 5 bits, MSB first.
REQ-025 If PHYAD != PHY_ADDR, the FSM SHALL enter SKIP after REGAD, consume 18 bits with mdio_oe held at 0 throughout, then return to IDLE without pulsing frame_err.
REQ-026 Read, TA bit 1: mdio_oe SHALL remain 0.
REQ-027 Read, TA bit 2: on the mdc_fall after the first TA rise, mdio_oe SHALL become 1 and mdio_o SHALL become 0.
REQ-028 Read, data phase: on each subsequent mdc_fall the block SHALL drive the next read-data bit, MSB first, for 16 bits.
REQ-029 Read, release: on the mdc_fall after the 16th data rise, mdio_oe SHALL become 0 and the FSM SHALL go to IDLE.
REQ-030 Read data SHALL be latched once, at the end of REGAD.
REQ-031 Write, TA: the sampled TA SHALL equal 10; otherwise the block SHALL pulse frame_err, abandon the frame and go to SKIP for the remaining 16 bits.
REQ-032 Write, data phase: the block SHALL shift in 16 bits, MSB first.
REQ-033 Write, commit: on the 16th data rise the block SHALL pulse wr_strobe for 1 clk, update wr_addr/wr_data and apply the register map, then return to IDLE.
REQ-034 Register 0 SHALL be R/W with reset value 16'h1140.
REQ-035 A write to register 0 with bit15=1 SHALL store the data, and on the next clk register 0 SHALL return to 16'h1140 (self-clearing reset).
REQ-036 Register 1 SHALL be read-only with value 16'h7949 | (link_in << 2).
REQ-037 Registers 2 and 3 SHALL be read-only and return PHY_ID1 and PHY_ID2.
REQ-038 Register 17 SHALL be read-only with value {speed_in, 3'b000, link_in, 10'b0}, i.e. speed at bits [15:14] and link at bit 10.
REQ-039 All other registers SHALL read 16'h0000, and writes to them SHALL be ignored apart from wr_strobe/wr_addr/wr_data.
REQ-040 Writes to read-only registers SHALL pulse wr_strobe but SHALL leave the register value unchanged.
REQ-041 A frame following a completed frame SHALL require a new preamble; the preamble count SHALL restart at 0 on return to IDLE.
REQ-042 frame_err SHALL pulse exactly once per malformed frame.
REQ-043 wr_strobe and frame_err SHALL never both be 1 in the same clk.

Reset
REQ-044 While rst=1, on every clk:
- FSM = IDLE, counters = 0.
- mdio_oe = 0, mdio_o = 1.
- ctrl_reg = 16'h1140.
- wr_strobe = 0, frame_err = 0, wr_addr = 0, wr_data = 0.
- synchronizers and prev = 1.
REQ-045 rst asserted mid-frame SHALL release MDIO on the next clk and discard the frame.
REQ-046 rst SHALL take priority over a coincident MDC edge.

Verification
REQ-047 Read reg 17:
- Stimulus: link_in=1, speed_in=01; 32x1 preamble, then 01 10 00001 10001.
- Response: oe stays 0 during TA bit 1; drives 0 during TA bit 2; then serializes 16'h4400 MSB first; releases after bit 16.
REQ-048 Write reg 0:
- Stimulus: data 16'h2100 with TA=10.
- Response: wr_strobe pulses once; wr_addr = 0; ctrl_reg = 16'h2100; a readback returns 16'h2100.
REQ-049 Address mismatch:
- Stimulus: PHYAD = 00010 read frame.
- Response: mdio_oe remains 0 for the whole frame; no frame_err; a following valid frame is answered.
REQ-050 Preamble and frame errors:
- Stimulus: 31-bit preamble.
- Response: frame ignored.
- Stimulus: OP = 11.
- Response: frame_err pulses once; return to IDLE.
- Stimulus: write with TA = 11.
- Response: frame_err pulses; no wr_strobe.
REQ-051 Self-clearing reset:
- Stimulus: write 16'h9140 to reg 0.
- Response: ctrl_reg = 16'h9140 for 1 clk, then 16'h1140.
REQ-052 Reset mid-read:
- Stimulus: assert rst during data bit 8.
- Response: mdio_oe = 0 on the next clk; after deassert, a fresh full frame reads correctly.

Source files
------------

// File: rtl/mdio_if.sv
// MDIO management bus between a station manager and a PHY responder.
// The station drives mdc/mdio_i; the responder drives mdio_o/mdio_oe.
interface mdio_if;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_oe;

  modport master (
    output mdc,
    output mdio_i,
    input  mdio_o,
    input  mdio_oe
  );

  modport slave (
    input  mdc,
    input  mdio_i,
    output mdio_o,
    output mdio_oe
  );
endinterface

// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on clk and serves
// a small register map (control, status, PHY ID, vendor status).
module mdio_slave #(
  parameter logic [4:0]  PHY_ADDR     = 5'b00001,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1622
) (
  input  logic        clk,
  input  logic        rst,
  mdio_if.slave       bus,
  input  logic        link_in,
  input  logic [1:0]  speed_in,
  output logic [15:0] ctrl_reg,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  localparam logic [6:0]  PRE_MIN  = 7'(PREAMBLE_MIN);
  localparam logic [15:0] CTRL_RST = 16'h1140;

  typedef enum logic [3:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP
  } state_t;

  state_t      state;
  logic [2:0]  mdc_sync;
  logic [1:0]  mdio_sync;
  logic [5:0]  pre_cnt;
  logic [4:0]  bit_cnt;
  logic        op_buf;
  logic        op_rd;
  logic        ta_hi;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] shreg;
  logic        drv_bit;
  logic        drv_en;

  logic        rise;
  logic        fall;
  logic        din;
  logic [4:0]  regad_n;
  logic [15:0] wdata_n;
  logic [15:0] rd_mux;

  assign rise    = mdc_sync[1] & ~mdc_sync[2];
  assign fall    = ~mdc_sync[1] & mdc_sync[2];
  assign din     = mdio_sync[1];
  assign regad_n = {regad[3:0], din};
  assign wdata_n = {shreg[14:0], din};

  assign bus.mdio_o  = drv_bit;
  assign bus.mdio_oe = drv_en;

  always_comb begin
    rd_mux = 16'h0000;
    case (regad_n)
      5'd0:    rd_mux = ctrl_reg;
      5'd1:    rd_mux = 16'h7949 | {13'b0, link_in, 2'b00};
      5'd2:    rd_mux = PHY_ID1;
      5'd3:    rd_mux = PHY_ID2;
      5'd17:   rd_mux = {speed_in, 3'b000, link_in, 10'b0};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_sync  <= 3'b111;
      mdio_sync <= 2'b11;
      state     <= IDLE;
      pre_cnt   <= '0;
      bit_cnt   <= '0;
      op_buf    <= 1'b0;
      op_rd     <= 1'b0;
      ta_hi     <= 1'b0;
      phyad     <= '0;
      regad     <= '0;
      shreg     <= '0;
      drv_bit   <= 1'b1;
      drv_en    <= 1'b0;
      ctrl_reg  <= CTRL_RST;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      mdc_sync  <= {mdc_sync[1:0], bus.mdc};
      mdio_sync <= {mdio_sync[0], bus.mdio_i};
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      // Bit 15 is a self-clearing soft reset of the control register
      if (ctrl_reg[15]) ctrl_reg <= CTRL_RST;
      if (rise) begin
        unique case (state)
          IDLE: begin
            if (din) begin
              if (pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;
            end else begin
              pre_cnt <= '0;
              if ({1'b0, pre_cnt} >= PRE_MIN) state <= ST;
            end
          end
          ST: begin
            bit_cnt <= '0;
            if (din) begin
              state <= OP;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
          OP: begin
            if (bit_cnt == 5'd0) begin
              op_buf  <= din;
              bit_cnt <= 5'd1;
            end else if (op_buf != din) begin
              op_rd   <= op_buf;
              bit_cnt <= '0;
              state   <= PHYAD;
            end else begin
              frame_err <= 1'b1;
              bit_cnt   <= '0;
              state     <= IDLE;
            end
          end
          PHYAD: begin
            phyad <= {phyad[3:0], din};
            if (bit_cnt == 5'd4) begin
              bit_cnt <= '0;
              state   <= REGAD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          REGAD: begin
            regad <= regad_n;
            if (bit_cnt != 5'd4) begin
              bit_cnt <= bit_cnt + 5'd1;
            end else if (phyad != PHY_ADDR) begin
              bit_cnt <= 5'd18;
              state   <= SKIP;
            end else begin
              shreg   <= rd_mux;
              bit_cnt <= '0;
              state   <= TA;
            end
          end
          TA: begin
            if (bit_cnt == 5'd0) begin
              ta_hi   <= din;
              bit_cnt <= 5'd1;
            end else if (op_rd) begin
              bit_cnt <= '0;
              state   <= RDATA;
            end else if (ta_hi && !din) begin
              bit_cnt <= '0;
              state   <= WDATA;
            end else begin
              frame_err <= 1'b1;
              bit_cnt   <= 5'd16;
              state     <= SKIP;
            end
          end
          WDATA: begin
            shreg <= wdata_n;
            if (bit_cnt == 5'd15) begin
              wr_strobe <= 1'b1;
              wr_addr   <= regad;
              wr_data   <= wdata_n;
              if (regad == 5'd0) ctrl_reg <= wdata_n;
              bit_cnt   <= '0;
              state     <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          RDATA: bit_cnt <= bit_cnt + 5'd1;
          SKIP: begin
            if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt - 5'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (fall) begin
        // Output side: turnaround zero, then data, then release
        if (state == TA && op_rd && bit_cnt == 5'd1) begin
          drv_en  <= 1'b1;
          drv_bit <= 1'b0;
        end else if (state == RDATA) begin
          if (bit_cnt == 5'd16) begin
            drv_en  <= 1'b0;
            drv_bit <= 1'b1;
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            drv_bit <= shreg[15];
            shreg   <= {shreg[14:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// Directed and randomized MDIO frames checked against a
// register-map model built from the documented behaviour.
module tb_mdio_slave;
  localparam logic [4:0] PHY = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_in;
  logic [1:0]  speed_in;
  logic [15:0] ctrl_reg;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;

  mdio_if bus();

  mdio_slave dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .link_in  (link_in),
    .speed_in (speed_in),
    .ctrl_reg (ctrl_reg),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  int n_strobe = 0;
  int n_err = 0;
  int n_both = 0;
  int n_9140 = 0;
  logic [15:0] ctrl_m = 16'h1140;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) n_strobe <= n_strobe + 1;
    if (frame_err === 1'b1) n_err <= n_err + 1;
    if (wr_strobe === 1'b1 && frame_err === 1'b1) n_both <= n_both + 1;
    if (ctrl_reg === 16'h9140) n_9140 <= n_9140 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [4:0] a);
    case (a)
      5'd0:    return ctrl_m;
      5'd1:    return 16'h7949 | (16'(link_in) << 2);
      5'd2:    return 16'h0022;
      5'd3:    return 16'h1622;
      5'd17:   return {speed_in, 3'b000, link_in, 10'b0};
      default: return 16'h0000;
    endcase
  endfunction

  // One MDC period; returns what the PHY drives just before the rise
  task automatic cyc(input logic b, output logic oe, output logic o);
    bus.mdio_i = b;
    #80;
    oe = bus.mdio_oe;
    o  = bus.mdio_o;
    bus.mdc = 1'b1;
    #80;
    bus.mdc = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic oe, o;
    for (int i = n - 1; i >= 0; i--) cyc(v[i], oe, o);
  endtask

  task automatic hdr(input int pre, input logic [1:0] op,
                     input logic [4:0] phy, input logic [4:0] ra);
    for (int i = 0; i < pre; i++) send(32'd1, 1);
    send({18'b0, 2'b01, op, phy, ra}, 14);
  endtask

  task automatic rd_body(output logic [15:0] data, output logic [17:0] oev,
                         output logic o_ta2, output logic oe_after);
    logic oe, o;
    data = '0;
    o_ta2 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, oe, o);
      oev[17-i] = oe;
      if (i == 1) o_ta2 = o;
      if (i >= 2) data[17-i] = o;
    end
    cyc(1'b1, oe_after, o);
  endtask

  task automatic rd_frame(input logic [4:0] phy, input logic [4:0] ra,
                          output logic [15:0] data, output logic [17:0] oev,
                          output logic o_ta2, output logic oe_after);
    hdr(32, 2'b10, phy, ra);
    rd_body(data, oev, o_ta2, oe_after);
  endtask

  task automatic wr_frame(input logic [4:0] phy, input logic [4:0] ra,
                          input logic [1:0] ta, input logic [15:0] d);
    hdr(32, 2'b01, phy, ra);
    send({30'b0, ta}, 2);
    send({16'b0, d}, 16);
    send(32'd1, 1);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] ra);
    logic [15:0] d, exp;
    logic [17:0] oev;
    logic ta2, oa;
    int e0;
    exp = model_rd(ra);
    e0 = n_err;
    rd_frame(PHY, ra, d, oev, ta2, oa);
    chk({tag, "_data"}, 32'(d), 32'(exp));
    chk({tag, "_oe"}, 32'(oev), 32'h1FFFF);
    chk({tag, "_ta2"}, 32'(ta2), 32'd0);
    chk({tag, "_rel"}, 32'(oa), 32'd0);
    chk({tag, "_err"}, 32'(n_err - e0), 32'd0);
  endtask

  task automatic wr_check(input string tag, input logic [4:0] ra,
                          input logic [15:0] d);
    int s0;
    s0 = n_strobe;
    wr_frame(PHY, ra, 2'b10, d);
    if (ra == 5'd0) ctrl_m = d[15] ? 16'h1140 : d;
    chk({tag, "_strobe"}, 32'(n_strobe - s0), 32'd1);
    chk({tag, "_addr"}, 32'(wr_addr), 32'(ra));
    chk({tag, "_wdata"}, 32'(wr_data), 32'(d));
    chk({tag, "_ctrl"}, 32'(ctrl_reg), 32'(ctrl_m));
  endtask

  initial begin
    logic [15:0] d;
    logic [17:0] oev;
    logic ta2, oa, oe, o;
    int s0, e0, c0;
    logic [4:0] ra;
    logic [4:0] pick [6];

    rst = 1'b1;
    bus.mdc = 1'b0;
    bus.mdio_i = 1'b1;
    link_in = 1'b1;
    speed_in = 2'b01;
    #50;
    chk("rst_oe", 32'(bus.mdio_oe), 32'd0);
    chk("rst_o", 32'(bus.mdio_o), 32'd1);
    chk("rst_ctrl", 32'(ctrl_reg), 32'h1140);
    chk("rst_pulses", 32'({wr_strobe, frame_err}), 32'd0);
    chk("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
    rst = 1'b0;
    #100;

    rd_check("rd17", 5'd17);
    chk("rd17_const", 32'(model_rd(5'd17)), 32'h4400);

    wr_check("wr0", 5'd0, 16'h2100);
    rd_check("rb0", 5'd0);

    e0 = n_err;
    rd_frame(5'b00010, 5'd17, d, oev, ta2, oa);
    chk("mis_oe", 32'(oev), 32'd0);
    chk("mis_rel", 32'(oa), 32'd0);
    chk("mis_err", 32'(n_err - e0), 32'd0);
    rd_check("after_mis", 5'd2);

    e0 = n_err;
    send(32'd0, 1);
    hdr(31, 2'b10, PHY, 5'd17);
    rd_body(d, oev, ta2, oa);
    chk("pre31_oe", 32'(oev), 32'd0);
    chk("pre31_err", 32'(n_err - e0), 32'd0);
    rd_check("after_pre31", 5'd3);

    e0 = n_err;
    s0 = n_strobe;
    hdr(32, 2'b11, PHY, 5'd0);
    rd_body(d, oev, ta2, oa);
    chk("op11_err", 32'(n_err - e0), 32'd1);
    chk("op11_oe", 32'(oev), 32'd0);
    chk("op11_strobe", 32'(n_strobe - s0), 32'd0);
    rd_check("after_op11", 5'd1);

    e0 = n_err;
    s0 = n_strobe;
    wr_frame(PHY, 5'd0, 2'b11, 16'h0100);
    chk("ta11_err", 32'(n_err - e0), 32'd1);
    chk("ta11_strobe", 32'(n_strobe - s0), 32'd0);
    chk("ta11_ctrl", 32'(ctrl_reg), 32'(ctrl_m));
    rd_check("after_ta11", 5'd0);

    c0 = n_9140;
    wr_check("sc", 5'd0, 16'h9140);
    chk("sc_1clk", 32'(n_9140 - c0), 32'd1);

    wr_check("ro1", 5'd1, 16'hFFFF);
    rd_check("ro1_rb", 5'd1);

    pick[0] = 5'd0; pick[1] = 5'd1; pick[2] = 5'd2;
    pick[3] = 5'd3; pick[4] = 5'd17; pick[5] = 5'd0;
    for (int k = 0; k < 12; k++) begin
      link_in = 1'($urandom);
      speed_in = 2'($urandom_range(0, 2));
      pick[5] = 5'($urandom);
      ra = pick[$urandom_range(0, 5)];
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) wr_check("rnd_wr", ra, d);
      else rd_check("rnd_rd", ra);
    end

    link_in = 1'b1;
    speed_in = 2'b01;
    hdr(32, 2'b10, PHY, 5'd17);
    for (int i = 0; i < 9; i++) cyc(1'b1, oe, o);
    bus.mdio_i = 1'b1;
    #80;
    chk("midrd_oe", 32'(bus.mdio_oe), 32'd1);
    bus.mdc = 1'b1;
    #40;
    rst = 1'b1;
    #10;
    chk("midrd_rst_oe", 32'(bus.mdio_oe), 32'd0);
    #30;
    bus.mdc = 1'b0;
    #40;
    rst = 1'b0;
    ctrl_m = 16'h1140;
    chk("midrd_ctrl", 32'(ctrl_reg), 32'h1140);
    rd_check("post_rst", 5'd17);

    chk("never_both", 32'(n_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
